// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: serialises {cmd,din} frames onto SS_n/MOSI and captures the
// 8-bit MISO reply of read-data frames.
module spi_master_ctrl #(
  parameter int RD_LAT = 3,
  parameter int GAP    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] cmd,
  input  logic [7:0] din,
  output logic       busy,
  output logic       done,
  output logic [7:0] dout,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRE   = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_CAPT  = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;
  logic [2:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [9:0] frame_q, frame_d;
  logic [7:0] sh_q, sh_d, dout_q, dout_d;
  logic       ss_n_q, ss_n_d, mosi_q, mosi_d, busy_q, busy_d, done_q, done_d;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    sh_d    = sh_q;
    dout_d  = dout_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_PRE;
        frame_d = {cmd, din};
      end
      S_PRE: begin
        state_d = S_SHIFT;
        cnt_d   = 4'd9;
      end
      S_SHIFT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd0) begin
          state_d = &frame_q[9:8] ? S_WAIT : S_GAP;
          cnt_d   = &frame_q[9:8] ? 4'(RD_LAT - 1) : 4'(GAP - 1);
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd0) begin
          state_d = S_CAPT;
          cnt_d   = 4'd7;
        end
      end
      S_CAPT: begin
        sh_d  = {sh_q[6:0], MISO};
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd0) begin
          state_d = S_GAP;
          cnt_d   = 4'(GAP - 1);
          dout_d  = sh_d;
        end
      end
      S_GAP: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // outputs are registered from the next state so they line up with it
    ss_n_d = (state_d == S_IDLE) || (state_d == S_GAP);
    mosi_d = state_d == S_PRE ? frame_d[9] : state_d == S_SHIFT ? frame_d[cnt_d] : 1'b0;
    busy_d = state_d != S_IDLE;
    done_d = (state_d == S_GAP) && (state_q != S_GAP);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      frame_q <= 10'd0;
      sh_q    <= 8'd0;
      dout_q  <= 8'd0;
      ss_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      sh_q    <= sh_d;
      dout_q  <= dout_d;
      ss_n_q  <= ss_n_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign SS_n = ss_n_q;
  assign MOSI = mosi_q;
  assign busy = busy_q;
  assign done = done_q;
  assign dout = dout_q;
endmodule
